fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
- Instruction-fetch stage directly upstream of instruction decode.
- Fetches sequential 32-bit instructions from a byte-wide instruction memory port, four little-endian byte reads per word, and tags each word with its address.
- Holds the tagged words in a small FIFO and presents the word whose address matches decode's PC.
- Any PC discontinuity (jump, branch resolution, misprediction) is detected as a tag mismatch; the queue is flushed and refetched from the new PC.

Parameters:
DEPTH, 4, number of queue entries; power of two, >= 2
NOP_INST, 32'h00000013, value driven on inst when no valid word is available

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
pc  input  32  current PC from decode; bits [1:0] ignored
pc_advance  input  1  decode will move PC to PC+4 at the next edge (the current inst is consumed)
inst  output  32  instruction for decode
inst_valid  output  1  inst corresponds to pc
fetch_stall  output  1  equals !inst_valid; OR-ed into the CPU freeze
imem_req  output  1  byte read request
imem_addr  output  32  byte address of the request
imem_ready  input  1  request accepted; imem_rdata valid this cycle
imem_rdata  input  8  read byte
queue_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
Reset (rst=0, async):
- Queue empty; queue_count=0.
- fetch_pc=0; byte index=0; state=FETCH.
- imem_req=0; imem_addr=0.
- inst=NOP_INST; inst_valid=0; fetch_stall=1.

Entry format and output:
- Each entry is {tag=addr[31:2], word[31:0]}.
- inst_valid=1 iff the queue is non-empty and head.tag==pc[31:2]; then inst=head.word, else inst=NOP_INST.
- Output is combinational from the registered queue; a push is never bypassed (visible the cycle after it is written).

Pop:
- At an edge where inst_valid && pc_advance, the head is removed.
- pc_advance with inst_valid=0 is ignored.

Redirect (evaluated combinationally each cycle):
- redirect = (queue non-empty && head.tag!=pc[31:2]) || (queue empty && fetch_pc[31:2]!=pc[31:2]).
- At the edge:
  - Queue cleared; any simultaneous pop or push is discarded.
  - fetch_pc<={pc[31:2],2'b00}; byte index<=0; partial word discarded.

States:
- IDLE: no request outstanding, queue full.
  - Go to FETCH when count<DEPTH.
- FETCH: imem_req=1, imem_addr=fetch_pc+byte_index.
  - Start a new word (byte index 0) only when count<DEPTH. Only one word is ever in flight, so space is guaranteed at completion.
  - Request and address are held stable until imem_ready.
  - On imem_ready: byte k is captured into bits [8k+7:8k] and the index increments.
  - On byte 3: push {fetch_pc[31:2], assembled word}, fetch_pc+=4, index wraps to 0.
  - Next state is FETCH if count-after-push<DEPTH, else IDLE.
- DRAIN: entered on redirect while imem_req=1 and imem_ready=0.
  - imem_req stays high with the old address until imem_ready; the returned byte is discarded.
  - Then go to FETCH at byte 0 of the new fetch_pc.
  - A redirect on the same cycle as imem_ready in FETCH goes directly to FETCH (no DRAIN).
  - A redirect while already in DRAIN only updates fetch_pc; the state stays DRAIN.

Timing and boundaries:
- Redirect latency with single-cycle imem_ready: mismatch at cycle t, new requests cycles t+1..t+4, push at edge end of t+4, inst_valid at t+5.
- Full queue and a pop on the same edge: count decrements and IDLE→FETCH on the next cycle.
- A push and a pop on the same edge leave count unchanged.
- Pointers wrap modulo DEPTH.
- fetch_pc wraps at 2^32 (0xFFFFFFFC+4 → 0).
- Reset mid-word abandons the request immediately; no DRAIN.

Test Plan:
- Reset release, pc=0, memory bytes 13 00 00 00 93 00 10 00, imem_ready always 1 → imem_addr 0,1,2,3 on consecutive cycles; inst_valid at cycle 5 with inst=32'h00000013; the next entry holds 32'h00100093.
- pc held at 0, pc_advance=0 → queue fills to count=4 (tags 0,1,2,3); imem_req drops (IDLE); one pop → imem_req reasserts at addr 0x10 the next cycle.
- Queue holds 0x0..0xC, pc jumps to 0x40 → queue_count=0 next cycle; requests 0x40..0x43; inst_valid 5 cycles after the jump; fetch_stall=1 throughout.
- Redirect to 0x80 while the request at addr 0x06 is pending (imem_ready low 3 cycles) → imem_addr stays 0x06 until ready; that byte is dropped; next request is 0x80.
- Sequential run with pc_advance every valid cycle, imem_ready every 4th cycle → no word is lost or duplicated; inst sequence matches memory word order.
- rst asserted mid-word (byte 2 of 0x20) → imem_req=0 immediately (async), count=0, inst=NOP_INST; after release, fetch restarts at pc.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
//
// Instruction-fetch stage that sits in front of decode. It reads sequential
// 32-bit instructions from a byte-wide memory port, four little-endian bytes
// per word. Each word is tagged with its word address and stored in a small
// FIFO. The entry whose tag matches decode's PC is presented on inst.
//
// A PC discontinuity shows up as a tag mismatch against the queue head, or
// against fetch_pc when the queue is empty. That mismatch flushes the queue
// and restarts fetching at the new PC.
//
// Handshake (memory port): imem_req/imem_addr are registered and held stable
// while imem_req=1 and imem_ready=0. A byte transfers on a rising edge where
// imem_req=1 and imem_ready=1; imem_rdata is valid in that same cycle. The
// request may only change after such a transfer, or on reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   pc           decode's current PC (bits [1:0] ignored)
//   pc_advance   decode consumes inst this cycle (honoured only if inst_valid)
//   inst         head word when it matches pc, else NOP_INST
//   inst_valid   inst corresponds to pc
//   fetch_stall  !inst_valid
//   imem_req     byte read request (registered)
//   imem_addr    byte address of the request (registered)
//   imem_ready   request accepted, imem_rdata valid
//   imem_rdata   returned byte
//   queue_count  occupied queue entries
//   fsm_state    current fetch FSM state (0 IDLE, 1 FETCH, 2 DRAIN)
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pc,
  input  logic                     pc_advance,
  output logic [31:0]              inst,
  output logic                     inst_valid,
  output logic                     fetch_stall,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ready,
  input  logic [7:0]               imem_rdata,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic [1:0]               fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [29:0]     fpc_q, fpc_d;     // word address currently being fetched
  logic [1:0]      idx_q, idx_d;     // next byte within the word
  logic [23:0]     part_q, part_d;   // bytes 0..2 of the word being assembled
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [29:0]     tag_mem  [DEPTH];
  logic [31:0]     word_mem [DEPTH];

  logic [29:0]     head_tag;
  logic [31:0]     head_word;
  logic            q_empty;
  logic            redirect;
  logic            xfer;
  logic            pop;
  logic            push;
  logic [31:0]     word_full;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^pc[1:0];

  assign head_tag   = tag_mem[rd_ptr_q];
  assign head_word  = word_mem[rd_ptr_q];
  assign q_empty    = (count_q == '0);
  assign inst_valid = !q_empty && (head_tag == pc[31:2]);
  assign inst       = inst_valid ? head_word : NOP_INST;
  assign fetch_stall = !inst_valid;

  // An empty queue still compares against fetch_pc, so a jump is noticed
  // even before the first word of the current stream has arrived.
  assign redirect = q_empty ? (fpc_q != pc[31:2]) : (head_tag != pc[31:2]);

  assign xfer      = req_q && imem_ready;
  assign word_full = {imem_rdata, part_q};
  assign pop       = inst_valid && pc_advance && !redirect;
  assign push      = (state_q == ST_FETCH) && xfer && (idx_q == 2'd3) && !redirect;

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    idx_d    = idx_q;
    part_d   = part_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      fpc_d    = pc[31:2];
      idx_d    = 2'd0;
      // A byte already requested but not yet accepted must be drained before
      // the address may change; the drained byte is thrown away.
      if (state_q == ST_DRAIN) begin
        state_d = xfer ? ST_FETCH : ST_DRAIN;
      end else if ((state_q == ST_FETCH) && req_q && !imem_ready) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (count_d < DEPTH_C) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (xfer) begin
            case (idx_q)
              2'd0: part_d[7:0]   = imem_rdata;
              2'd1: part_d[15:8]  = imem_rdata;
              2'd2: part_d[23:16] = imem_rdata;
              default: part_d = part_q;
            endcase
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              fpc_d   = fpc_q + 30'd1;
              state_d = (count_d < DEPTH_C) ? ST_FETCH : ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (xfer) state_d = ST_FETCH;
        end
        default: state_d = ST_FETCH;
      endcase
    end

    // Request for the next cycle, derived from where the FSM is going.
    // A new word starts only when there is room; a word in progress always
    // continues, since space was reserved when it started.
    req_d  = 1'b0;
    addr_d = addr_q;
    if (state_d == ST_DRAIN) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else if (state_d == ST_FETCH) begin
      req_d  = (idx_d != 2'd0) || (count_d < DEPTH_C);
      addr_d = {fpc_d, idx_d};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_FETCH;
      fpc_q    <= '0;
      idx_q    <= '0;
      part_q   <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      idx_q    <= idx_d;
      part_q   <= part_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q]  <= fpc_q;
      word_mem[wr_ptr_q] <= word_full;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign queue_count = count_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  localparam int M_ALWAYS = 0;
  localparam int M_EVERY4 = 1;
  localparam int M_HOLD   = 2;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_advance;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [7:0]  imem_rdata;
  logic [2:0]  queue_count;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int mode   = M_ALWAYS;
  int cyc    = 0;
  int consumed = 0;
  logic [31:0] exp_q[$];

  fetch_prefetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_advance  (pc_advance),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .fetch_stall (fetch_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .queue_count (queue_count),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model ----------------
  // Bytes 0..7: 13 00 00 00 93 00 10 00; elsewhere a fixed address pattern.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] w8;
    w8 = a[9:2];
    if (a < 32'd8) begin
      case (a[2:0])
        3'd0:    return 8'h13;
        3'd4:    return 8'h93;
        3'd6:    return 8'h10;
        default: return 8'h00;
      endcase
    end
    case (a[1:0])
      2'd0:    return w8;
      2'd1:    return w8 ^ 8'hA5;
      2'd2:    return ~w8;
      default: return w8 + 8'h11;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:2], 2'b00};
    return {mem_byte(b + 32'd3), mem_byte(b + 32'd2), mem_byte(b + 32'd1), mem_byte(b)};
  endfunction

  // Memory responder: decides ready and data away from the rising edge.
  initial begin
    imem_ready = 1'b0;
    imem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      case (mode)
        M_ALWAYS: imem_ready = imem_req;
        M_EVERY4: imem_ready = imem_req && ((cyc % 4) == 0);
        default:  imem_ready = 1'b0;
      endcase
      imem_rdata = imem_ready ? mem_byte(imem_addr) : 8'h00;
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // Every consumed instruction is compared with the oldest expected word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst && inst_valid && pc_advance) begin
        consumed++;
        if (exp_q.size() == 0) begin
          check("consume_unexpected", inst, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check("consume_inst", inst, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int target, input int budget);
    int i;
    i = 0;
    while ((int'(queue_count) != target) && (i < budget)) begin
      tick();
      i++;
    end
    check("fill_count", 32'(queue_count), 32'(target));
  endtask

  // Decode model: advance whenever the presented word is valid.
  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (pc_advance) begin
        pc = pc + 32'd4;
        pc_advance = 1'b0;
      end
      #1;
      if (inst_valid) begin
        pc_advance = 1'b1;
        exp_q.push_back(exp_word(pc));
      end
    end
    tick();
    if (pc_advance) pc = pc + 32'd4;
    pc_advance = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0;
    rst = 1'b0;
    pc = 32'h0;
    pc_advance = 1'b0;
    mode = M_ALWAYS;
    tick();
    tick();

    // reset state
    check("rst_count", 32'(queue_count), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_inst", inst, NOP);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_stall", 32'(fetch_stall), 32'd1);

    // first word after reset release
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("boot_req", 32'(imem_req), 32'd1);
      check("boot_addr", imem_addr, 32'(k));
      check("boot_valid", 32'(inst_valid), 32'd0);
    end
    tick();
    check("boot_valid5", 32'(inst_valid), 32'd1);
    check("boot_inst", inst, 32'h00000013);
    check("boot_count", 32'(queue_count), 32'd1);
    check("boot_stall", 32'(fetch_stall), 32'd0);

    // fill to full, then one pop restarts fetch at 0x10
    wait_count(4, 40);
    check("full_req", 32'(imem_req), 32'd0);
    tick();
    check("full_req_hold", 32'(imem_req), 32'd0);
    check("full_count_hold", 32'(queue_count), 32'd4);
    pc_advance = 1'b1;
    exp_q.push_back(32'h00000013);
    tick();
    check("refill_req", 32'(imem_req), 32'd1);
    check("refill_addr", imem_addr, 32'h10);
    check("pop_count", 32'(queue_count), 32'd3);
    pc = 32'h4;
    pc_advance = 1'b0;
    #1;
    check("second_valid", 32'(inst_valid), 32'd1);
    check("second_inst", inst, 32'h00100093);

    // jump from a full queue to 0x40
    wait_count(4, 20);
    pc = 32'h40;
    #1;
    check("jump_stall0", 32'(fetch_stall), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) check("jump_flush_count", 32'(queue_count), 32'd0);
      check("jump_addr", imem_addr, 32'h40 + 32'(k));
      check("jump_stall", 32'(fetch_stall), 32'd1);
    end
    tick();
    check("jump_valid", 32'(inst_valid), 32'd1);
    check("jump_inst", inst, 32'h21EFB510);

    // redirect while the request at 0x06 is stalled
    pc = 32'h4;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("pre_drain_addr", imem_addr, 32'h4 + 32'(k));
    end
    mode = M_HOLD;
    pc = 32'h80;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("drain_req", 32'(imem_req), 32'd1);
      check("drain_addr", imem_addr, 32'h6);
      check("drain_count", 32'(queue_count), 32'd0);
    end
    mode = M_ALWAYS;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_drain_addr", imem_addr, 32'h80 + 32'(k));
      check("post_drain_stall", 32'(fetch_stall), 32'd1);
    end
    tick();
    check("post_drain_valid", 32'(inst_valid), 32'd1);
    check("post_drain_inst", inst, 32'h31DF8520);

    // sequential consumption with a slow memory
    mode = M_EVERY4;
    c0 = consumed;
    run_seq(100);
    check("slow_queue_empty", 32'(exp_q.size()), 32'd0);
    check("slow_progress", 32'(consumed - c0 >= 4), 32'd1);

    // sequential run across the top of the address space
    mode = M_ALWAYS;
    pc = 32'hFFFFFFF8;
    c0 = consumed;
    run_seq(40);
    check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    check("wrap_progress", 32'(consumed - c0 >= 4), 32'd1);
    check("wrap_pc_low", 32'(pc < 32'h100), 32'd1);

    // reset in the middle of the word at 0x20
    pc = 32'h20;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_addr", imem_addr, 32'h20 + 32'(k));
    end
    rst = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_count", 32'(queue_count), 32'd0);
    check("midrst_inst", inst, NOP);
    check("midrst_valid", 32'(inst_valid), 32'd0);
    tick();
    pc = 32'h8;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("restart_addr", imem_addr, 32'h8 + 32'(k));
    end
    tick();
    check("restart_valid", 32'(inst_valid), 32'd1);
    check("restart_inst", inst, 32'h13FDA702);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
